// File: rtl/aq_djpeg_stream_ctrl.sv
// JPEG marker-structure sequencer: walks SOI / length-prefixed segments / SOS and
// arbitrates every consume pulse to the bit buffer between header parser and Huffman decoder.
module aq_djpeg_stream_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        Abort,
    input  logic [31:0] DataOut,
    input  logic        DataOutEnable,
    output logic        UseBit,
    output logic [6:0]  UseWidth,
    output logic        UseByte,
    output logic        UseWord,
    output logic        ImageEnable,
    output logic        ProcessIdle,
    output logic [7:0]  MarkerCode,
    output logic        SegValid,
    output logic [15:0] SegRemain,
    input  logic        HdrByteReq,
    input  logic        HdrWordReq,
    output logic        HdrAck,
    input  logic        HufReq,
    input  logic [5:0]  HufWidth,
    output logic        HufAck,
    input  logic        DecodeDone,
    output logic        Error,
    output logic        Busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOI, S_MARKER, S_LENGTH, S_SEGMENT, S_IMAGE, S_DONE, S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] seg_remain_q, seg_remain_d;
    logic [7:0]  marker_q, marker_d;

    logic [15:0] win_hi;
    logic        huf_width_ok;
    state_e      seg_after;
    logic        unused_lo;

    assign win_hi       = DataOut[31:16];
    assign unused_lo    = ^DataOut[15:0];
    assign huf_width_ok = (HufWidth != 6'd0) && (HufWidth <= 6'd32);
    // SOS payload (or an empty SOS) hands over to entropy-coded data.
    assign seg_after    = (marker_q == 8'hDA) ? S_IMAGE : S_MARKER;

    always_comb begin
        state_d      = state_q;
        seg_remain_d = seg_remain_q;
        marker_d     = marker_q;
        UseBit       = 1'b0;
        UseWidth     = '0;
        UseByte      = 1'b0;
        UseWord      = 1'b0;
        HdrAck       = 1'b0;
        HufAck       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    state_d      = S_SOI;
                    seg_remain_d = '0;
                end
            end
            S_SOI: begin
                if (DataOutEnable) begin
                    if (win_hi == 16'hFFD8) begin
                        UseWord = 1'b1;
                        state_d = S_MARKER;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_MARKER: begin
                if (DataOutEnable) begin
                    if (win_hi[15:8] != 8'hFF) begin
                        state_d = S_ERROR;
                    end else if (win_hi[7:0] == 8'hFF) begin
                        UseByte = 1'b1;
                    end else if (win_hi[7:0] == 8'hD9) begin
                        UseWord = 1'b1;
                        state_d = S_DONE;
                    end else if ((win_hi[7:3] == 5'b11010) || (win_hi[7:0] == 8'h01)) begin
                        UseWord = 1'b1;
                    end else begin
                        UseWord  = 1'b1;
                        marker_d = win_hi[7:0];
                        state_d  = S_LENGTH;
                    end
                end
            end
            S_LENGTH: begin
                if (DataOutEnable) begin
                    UseWord = 1'b1;
                    if (win_hi < 16'd2) begin
                        state_d = S_ERROR;
                    end else if (win_hi == 16'd2) begin
                        state_d = seg_after;
                    end else begin
                        seg_remain_d = win_hi - 16'd2;
                        state_d      = S_SEGMENT;
                    end
                end
            end
            S_SEGMENT: begin
                if (seg_remain_q == 16'd0) begin
                    state_d = seg_after;
                end else if (HdrWordReq && (seg_remain_q == 16'd1)) begin
                    state_d = S_ERROR;
                end else if (DataOutEnable && HdrWordReq) begin
                    UseWord      = 1'b1;
                    HdrAck       = 1'b1;
                    seg_remain_d = seg_remain_q - 16'd2;
                    if (seg_remain_q == 16'd2) state_d = seg_after;
                end else if (DataOutEnable && HdrByteReq) begin
                    UseByte      = 1'b1;
                    HdrAck       = 1'b1;
                    seg_remain_d = seg_remain_q - 16'd1;
                    if (seg_remain_q == 16'd1) state_d = seg_after;
                end
            end
            S_IMAGE: begin
                if (HufReq && !huf_width_ok) begin
                    state_d = S_ERROR;
                end else begin
                    if (HufReq && DataOutEnable) begin
                        UseBit   = 1'b1;
                        UseWidth = {1'b0, HufWidth};
                        HufAck   = 1'b1;
                    end
                    if (DecodeDone) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including any pulse decided above.
        if (Abort) begin
            state_d      = S_IDLE;
            seg_remain_d = '0;
            UseBit       = 1'b0;
            UseWidth     = '0;
            UseByte      = 1'b0;
            UseWord      = 1'b0;
            HdrAck       = 1'b0;
            HufAck       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            seg_remain_q <= '0;
            marker_q     <= '0;
        end else begin
            state_q      <= state_d;
            seg_remain_q <= seg_remain_d;
            marker_q     <= marker_d;
        end
    end

    assign ImageEnable = (state_q == S_IMAGE);
    assign ProcessIdle = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign Busy        = !ProcessIdle;
    assign SegValid    = (state_q == S_SEGMENT);
    assign Error       = (state_q == S_ERROR);
    assign SegRemain   = seg_remain_q;
    assign MarkerCode  = marker_q;

endmodule

// File: tb/tb_aq_djpeg_stream_ctrl.sv
// Directed bench for aq_djpeg_stream_ctrl: vector table for the main streams,
// hand sequences for error, fill-byte and abort corners.
module tb_aq_djpeg_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        Start, Abort;
    logic [31:0] DataOut;
    logic        DataOutEnable;
    logic        UseBit;
    logic [6:0]  UseWidth;
    logic        UseByte, UseWord;
    logic        ImageEnable, ProcessIdle;
    logic [7:0]  MarkerCode;
    logic        SegValid;
    logic [15:0] SegRemain;
    logic        HdrByteReq, HdrWordReq, HdrAck;
    logic        HufReq;
    logic [5:0]  HufWidth;
    logic        HufAck;
    logic        DecodeDone;
    logic        Error, Busy;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    aq_djpeg_stream_ctrl dut (
        .clk(clk), .rst(rst), .Start(Start), .Abort(Abort),
        .DataOut(DataOut), .DataOutEnable(DataOutEnable),
        .UseBit(UseBit), .UseWidth(UseWidth), .UseByte(UseByte), .UseWord(UseWord),
        .ImageEnable(ImageEnable), .ProcessIdle(ProcessIdle), .MarkerCode(MarkerCode),
        .SegValid(SegValid), .SegRemain(SegRemain),
        .HdrByteReq(HdrByteReq), .HdrWordReq(HdrWordReq), .HdrAck(HdrAck),
        .HufReq(HufReq), .HufWidth(HufWidth), .HufAck(HufAck),
        .DecodeDone(DecodeDone), .Error(Error), .Busy(Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        st, ab;
        logic [31:0] dout;
        logic        doe, hb, hw, hr;
        logic [5:0]  hwid;
        logic        dd;
        logic [40:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Pulse codes {UseBit,UseByte,UseWord}, ack codes {HdrAck,HufAck},
    // flag codes {ImageEnable,ProcessIdle,SegValid,Error,Busy}.
    localparam logic [2:0] P_N = 3'b000, P_BIT = 3'b100, P_BYTE = 3'b010, P_WORD = 3'b001;
    localparam logic [1:0] A_N = 2'b00, A_HDR = 2'b10, A_HUF = 2'b01;
    localparam logic [4:0] F_IDLE = 5'b01000, F_BUSY = 5'b00001, F_SEG = 5'b00101, F_IMG = 5'b10001;

    function automatic logic [40:0] ex(logic [2:0] p, logic [1:0] a, logic [6:0] w,
                                       logic [4:0] f, logic [7:0] mc, logic [15:0] sr);
        return {p[2], w, p[1], p[0], a, f, mc, sr};
    endfunction

    function automatic void add(string n, logic st, logic ab, logic [31:0] dout, logic doe,
                                logic hb, logic hw, logic hr, logic [5:0] hwid, logic dd,
                                logic [40:0] e);
        vec_t v;
        v.name = n; v.st = st; v.ab = ab; v.dout = dout; v.doe = doe;
        v.hb = hb; v.hw = hw; v.hr = hr; v.hwid = hwid; v.dd = dd; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic st, logic ab, logic [31:0] dout, logic doe, logic hb,
                         logic hw, logic hr, logic [5:0] hwid, logic dd);
        @(negedge clk);
        Start = st; Abort = ab; DataOut = dout; DataOutEnable = doe;
        HdrByteReq = hb; HdrWordReq = hw; HufReq = hr; HufWidth = hwid; DecodeDone = dd;
        #2;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [40:0] act;

    initial begin
        rst = 1'b0;
        Start = 0; Abort = 0; DataOut = '0; DataOutEnable = 0;
        HdrByteReq = 0; HdrWordReq = 0; HufReq = 0; HufWidth = '0; DecodeDone = 0;

        // Stream 1: FFD8 FFC4 0004 AB CD FFD9, header parser byte requests.
        add("reset_state", 0,0,32'h0000_0000,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_IDLE,8'h00,16'd0));
        add("start1",      1,0,32'h0000_0000,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_IDLE,8'h00,16'd0));
        add("soi1",        0,0,32'hFFD8_FFC4,1,0,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'h00,16'd0));
        add("mk_c4_wait",  0,0,32'hFFC4_0004,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_BUSY,8'h00,16'd0));
        add("mk_c4",       0,0,32'hFFC4_0004,1,0,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'h00,16'd0));
        add("len1_wait",   0,0,32'h0004_ABCD,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("len1",        0,0,32'h0004_ABCD,1,1,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("seg_wait1",   0,0,32'hABCD_FFD9,0,1,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_SEG, 8'hC4,16'd2));
        add("seg_byte1",   0,0,32'hABCD_FFD9,1,1,0,0,6'd0,0, ex(P_BYTE,A_HDR,7'd0, F_SEG, 8'hC4,16'd2));
        add("seg_wait2",   0,0,32'hCDFF_D900,0,1,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_SEG, 8'hC4,16'd1));
        add("seg_byte2",   0,0,32'hCDFF_D900,1,1,0,0,6'd0,0, ex(P_BYTE,A_HDR,7'd0, F_SEG, 8'hC4,16'd1));
        add("eoi_wait",    0,0,32'hFFD9_0000,0,1,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("eoi",         0,0,32'hFFD9_0000,1,0,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("done1",       0,0,32'hFFD8_0000,1,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_IDLE,8'hC4,16'd0));
        // Stream 2: FFD8 FFDA 0002, then Huffman bit requests.
        add("start2",      1,0,32'h0000_0000,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_IDLE,8'hC4,16'd0));
        add("soi2",        0,0,32'hFFD8_FFDA,1,0,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("mk_da_wait",  0,0,32'hFFDA_0002,0,0,0,0,6'd0,0, ex(P_N,   A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("mk_da",       0,0,32'hFFDA_0002,1,0,0,0,6'd0,0, ex(P_WORD,A_N,  7'd0, F_BUSY,8'hC4,16'd0));
        add("len2_wait",   0,0,32'h0002_ABCD,0,0,0,1,6'd13,0,ex(P_N,   A_N,  7'd0, F_BUSY,8'hDA,16'd0));
        add("len2",        0,0,32'h0002_ABCD,1,0,0,1,6'd13,0,ex(P_WORD,A_N,  7'd0, F_BUSY,8'hDA,16'd0));
        add("img_wait",    0,0,32'hABCD_1234,0,0,0,1,6'd13,0,ex(P_N,   A_N,  7'd0, F_IMG, 8'hDA,16'd0));
        add("huf13",       0,0,32'hABCD_1234,1,0,0,1,6'd13,0,ex(P_BIT, A_HUF,7'd13,F_IMG, 8'hDA,16'd0));
        add("huf_wait",    0,0,32'h1234_5678,0,0,0,1,6'd32,0,ex(P_N,   A_N,  7'd0, F_IMG, 8'hDA,16'd0));
        add("huf32_done",  0,0,32'h1234_5678,1,0,0,1,6'd32,1,ex(P_BIT, A_HUF,7'd32,F_IMG, 8'hDA,16'd0));
        add("done2",       0,0,32'h1234_5678,1,0,0,1,6'd13,0,ex(P_N,   A_N,  7'd0, F_IDLE,8'hDA,16'd0));

        #2;
        chk("in_reset_pidle", 64'(ProcessIdle), 64'd1);
        chk("in_reset_pulses", 64'({UseBit, UseByte, UseWord, UseWidth}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].dout, vecs[i].doe, vecs[i].hb,
                  vecs[i].hw, vecs[i].hr, vecs[i].hwid, vecs[i].dd);
            act = {UseBit, UseWidth, UseByte, UseWord, HdrAck, HufAck,
                   ImageEnable, ProcessIdle, SegValid, Error, Busy, MarkerCode, SegRemain};
            chk(vecs[i].name, 64'(act), 64'(vecs[i].exp));
        end

        // Bad SOI, Start clears Error, fill byte, marker latch, word request with one byte left.
        drive(1,0,32'h0,0,0,0,0,6'd0,0);
        drive(0,0,32'h1234_ABCD,1,0,0,0,6'd0,0);
        chk("soi_bad_nopulse", 64'({UseBit, UseByte, UseWord}), 64'd0);
        drive(0,0,32'hFFD8_FFFF,1,0,0,0,6'd0,0);
        chk("soi_bad_err", 64'({Error, ProcessIdle, Busy}), 64'b110);
        chk("err_nopulse", 64'({UseBit, UseByte, UseWord}), 64'd0);
        drive(1,0,32'hFFD8_FFFF,0,0,0,0,6'd0,0);
        drive(0,0,32'hFFD8_FFFF,1,0,0,0,6'd0,0);
        chk("start_clears_err", 64'({Error, Busy, UseWord}), 64'b011);
        drive(0,0,32'hFFFF_FFE0,1,0,0,0,6'd0,0);
        chk("fill_byte", 64'({UseByte, UseWord}), 64'b10);
        drive(0,0,32'hFFE0_0003,1,0,0,0,6'd0,0);
        chk("mk_e0_word", 64'({UseByte, UseWord}), 64'b01);
        drive(0,0,32'h0003_ABCD,1,0,0,0,6'd0,0);
        chk("mk_e0_latched", 64'(MarkerCode), 64'hE0);
        drive(0,0,32'hABCD_0000,1,0,1,0,6'd0,0);
        chk("seg1_state", 64'({SegValid, SegRemain}), 64'h1_0001);
        chk("seg1_word_refused", 64'({UseWord, UseByte, HdrAck}), 64'd0);
        drive(0,0,32'hABCD_0000,0,0,0,0,6'd0,0);
        chk("seg1_word_err", 64'(Error), 64'd1);

        // Abort from ERROR, then abort mid-IMAGE with Huffman requests held.
        drive(0,1,32'h0,0,0,0,0,6'd0,0);
        drive(0,0,32'h0,0,0,0,0,6'd0,0);
        chk("abort_err_idle", 64'({Error, ProcessIdle, Busy, SegRemain}), 64'({3'b010, 16'd0}));
        drive(1,0,32'h0,0,0,0,0,6'd0,0);
        drive(0,0,32'hFFD8_FFDA,1,0,0,0,6'd0,0);
        drive(0,0,32'hFFDA_0002,1,0,0,0,6'd0,0);
        drive(0,0,32'h0002_1111,1,0,0,1,6'd13,0);
        chk("sos_len_word", 64'({UseWord, UseBit}), 64'b10);
        drive(0,0,32'h1111_2222,1,0,0,1,6'd13,0);
        chk("img_bit", 64'({ImageEnable, UseBit, UseWidth}), 64'({2'b11, 7'd13}));
        drive(0,1,32'h1111_2222,1,0,0,1,6'd13,0);
        drive(0,0,32'h1111_2222,1,0,0,1,6'd13,0);
        chk("abort_img_state", 64'({ImageEnable, ProcessIdle, Busy}), 64'b010);
        chk("abort_img_nobit", 64'({UseBit, HufAck}), 64'd0);
        drive(0,0,32'h1111_2222,1,0,0,1,6'd13,0);
        chk("abort_img_nobit2", 64'(UseBit), 64'd0);

        // Illegal Huffman width.
        drive(1,0,32'h0,0,0,0,0,6'd0,0);
        drive(0,0,32'hFFD8_FFDA,1,0,0,0,6'd0,0);
        drive(0,0,32'hFFDA_0002,1,0,0,0,6'd0,0);
        drive(0,0,32'h0002_1111,1,0,0,0,6'd0,0);
        drive(0,0,32'h1111_2222,1,0,0,1,6'd0,0);
        chk("huf_w0_nobit", 64'({ImageEnable, UseBit}), 64'b10);
        drive(0,0,32'h1111_2222,0,0,0,0,6'd0,0);
        chk("huf_w0_err", 64'({Error, ImageEnable}), 64'b10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
